// File: rtl/light_pkg.sv
// Shared state encodings and default timing for the hallway light controller.
// Pure definitions; no logic, no latency, no flow control.
package light_pkg;

    typedef enum logic {LAMP_OFF, LAMP_ON} lamp_state_e;
    typedef enum logic {DB_STABLE, DB_COUNT} db_state_e;

    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT  = 64;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus debounce FSM; o_db flips DEBOUNCE_CYCLES+3 edges after a clean change.
// Free-running, one sample per clock, no backpressure; o_flip is high in the cycle before o_db moves.
module switch_debounce
    import light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_db,
    output logic o_flip
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES);

    logic       r_meta;
    logic       r_sync;
    logic       r_db;
    logic       w_db_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    db_state_e  r_state;
    db_state_e  w_state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
            r_state <= DB_STABLE;
        end else begin
            r_meta  <= i_raw;
            r_sync  <= r_meta;
            r_db    <= w_db_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_db_nxt    = r_db;
        case (r_state)
            DB_STABLE: begin
                if (r_sync != r_db) begin
                    w_state_nxt = DB_COUNT;
                    w_cnt_nxt   = 8'd1;
                end
            end
            DB_COUNT: begin
                // Any sample back at the old level restarts the qualification window.
                if (r_sync == r_db) begin
                    w_state_nxt = DB_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_db_nxt    = r_sync;
                    w_state_nxt = DB_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = DB_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_db   = r_db;
    assign o_flip = (w_db_nxt != r_db);

endmodule

// File: rtl/light_ctrl.sv
// Two-way hallway light: debounced switches toggle the lamp, optional auto-off timer.
// f moves on the same edge as the debounced input (DEBOUNCE_CYCLES+3 edges); no backpressure.
module light_ctrl
    import light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x1,
    input  logic x2,
    input  logic en,
    output logic f,
    output logic x1_db,
    output logic x2_db,
    output logic timeout
);

    localparam int          TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          w_flip1;
    logic          w_flip2;
    logic          w_tog;
    logic [TW-1:0] r_tmr;
    logic [TW-1:0] w_tmr_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;
    lamp_state_e   r_lamp;
    lamp_state_e   w_lamp_nxt;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_raw  (x1),
        .o_db   (x1_db),
        .o_flip (w_flip1)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_raw  (x2),
        .o_db   (x2_db),
        .o_flip (w_flip2)
    );

    // Flip strobes lead the debounced outputs by one cycle, so f lands with them.
    assign w_tog = w_flip1 ^ w_flip2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lamp    <= LAMP_OFF;
            r_tmr     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_lamp    <= w_lamp_nxt;
            r_tmr     <= w_tmr_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_lamp_nxt    = r_lamp;
        w_tmr_nxt     = '0;
        w_timeout_nxt = 1'b0;
        case (r_lamp)
            LAMP_OFF: begin
                if (w_tog) w_lamp_nxt = LAMP_ON;
            end
            LAMP_ON: begin
                if (w_tog) begin
                    w_lamp_nxt = LAMP_OFF;
                end else if (en) begin
                    if (r_tmr == TMR_LAST) begin
                        w_lamp_nxt    = LAMP_OFF;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_tmr_nxt = r_tmr + TW'(1);
                    end
                end
            end
            default: w_lamp_nxt = LAMP_OFF;
        endcase
    end

    assign f       = (r_lamp == LAMP_ON);
    assign timeout = r_timeout;

endmodule

// File: tb/tb_light_ctrl.sv
// Bench for light_ctrl: vector table, corner-case sequences and random stimulus vs a reference model.
module tb_light_ctrl;

    localparam int DB = 4;
    localparam int TO = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic x1    = 1'b0;
    logic x2    = 1'b0;
    logic en    = 1'b0;
    logic f, x1_db, x2_db, timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mchk  = 1'b0;

    light_ctrl #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x1      (x1),
        .x2      (x2),
        .en      (en),
        .f       (f),
        .x1_db   (x1_db),
        .x2_db   (x2_db),
        .timeout (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a debounced level flips once the last DB+1 synchronised samples
    // (raw samples two edges old) all disagree with it; the lamp is a toggle with an on-time limit.
    logic [DB+2:0] h1, h2;
    logic [DB+2:0] n1, n2;
    logic          m_db1, m_db2, m_f, m_to, c1, c2, tg, expire;
    int            m_on;

    function automatic logic settled(input logic [DB+2:0] h, input logic db);
        for (int i = 2; i <= DB + 2; i++)
            if (h[i] == db) return 1'b0;
        return 1'b1;
    endfunction

    assign n1     = {h1[DB+1:0], x1};
    assign n2     = {h2[DB+1:0], x2};
    assign c1     = settled(n1, m_db1);
    assign c2     = settled(n2, m_db2);
    assign tg     = c1 ^ c2;
    assign expire = !tg && m_f && en && (m_on == TO - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= '0; h2 <= '0;
            m_db1 <= 1'b0; m_db2 <= 1'b0; m_f <= 1'b0; m_to <= 1'b0; m_on <= 0;
        end else begin
            h1    <= n1;
            h2    <= n2;
            m_db1 <= m_db1 ^ c1;
            m_db2 <= m_db2 ^ c2;
            m_to  <= expire;
            if (tg) begin
                m_f  <= ~m_f;
                m_on <= 0;
            end else if (expire) begin
                m_f  <= 1'b0;
                m_on <= 0;
            end else begin
                m_on <= (m_f && en) ? m_on + 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mchk) begin
            chk("model f", f, m_f);
            chk("model x1_db", x1_db, m_db1);
            chk("model x2_db", x2_db, m_db2);
            chk("model timeout", timeout, m_to);
        end
    end

    // Drive a new switch level and require f to hold until exactly edge DB+3, then equal fexp.
    task automatic step(input string nm, input logic a, input logic b, input logic fexp);
        logic fprev;
        @(negedge clk);
        fprev = f;
        x1 = a;
        x2 = b;
        for (int i = 1; i <= DB + 3; i++) begin
            @(posedge clk); #1;
            chk(nm, f, (i == DB + 3) ? fexp : fprev);
        end
    endtask

    task automatic expiry(input string nm);
        for (int i = 1; i <= TO; i++) begin
            @(posedge clk); #1;
            chk({nm, " f"}, f, logic'(i < TO));
            chk({nm, " timeout"}, timeout, logic'(i == TO));
        end
        @(posedge clk); #1;
        chk({nm, " timeout end"}, timeout, 1'b0);
    endtask

    typedef struct {
        logic a;
        logic b;
        logic f;
        int   hold;
    } vec_t;

    vec_t tbl[6];
    int   cr;

    initial begin
        tbl[0] = '{a: 1'b1, b: 1'b0, f: 1'b1, hold: 100};
        tbl[1] = '{a: 1'b1, b: 1'b1, f: 1'b0, hold: 100};
        tbl[2] = '{a: 1'b0, b: 1'b1, f: 1'b1, hold: 100};
        tbl[3] = '{a: 1'b0, b: 1'b0, f: 1'b0, hold: 100};
        tbl[4] = '{a: 1'b1, b: 1'b1, f: 1'b0, hold: 30};
        tbl[5] = '{a: 1'b0, b: 1'b0, f: 1'b0, hold: 30};

        #2 rst_n = 1'b0;
        #1;
        chk("reset f", f, 1'b0);
        chk("reset x1_db", x1_db, 1'b0);
        chk("reset x2_db", x2_db, 1'b0);
        chk("reset timeout", timeout, 1'b0);
        mchk = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Switch walk and simultaneous change, en low.
        for (int i = 0; i < 6; i++) begin
            step($sformatf("walk%0d", i), tbl[i].a, tbl[i].b, tbl[i].f);
            repeat (tbl[i].hold - (DB + 3)) @(posedge clk);
            #1;
            chk($sformatf("walk%0d x1_db", i), x1_db, tbl[i].a);
            chk($sformatf("walk%0d x2_db", i), x2_db, tbl[i].b);
        end

        // Short pulse then bounce: no debounced change, then one clean settle.
        @(negedge clk) x1 = 1'b1;
        repeat (3) @(negedge clk);
        x1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("pulse f", f, 1'b0);
            chk("pulse x1_db", x1_db, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk) x1 = (i % 2 == 0);
            @(posedge clk); #1;
            chk("bounce x1_db", x1_db, 1'b0);
        end
        step("settle", 1'b1, 1'b0, 1'b1);
        chk("settle x1_db", x1_db, 1'b1);

        // Auto-off after a full period, then a single switch change relights.
        step("off", 1'b0, 1'b0, 1'b0);
        @(negedge clk) en = 1'b1;
        step("on", 1'b1, 1'b0, 1'b1);
        expiry("autooff");
        step("relight", 1'b1, 1'b1, 1'b1);

        // Toggle landing on the expiry edge wins and suppresses timeout.
        cr = cyc;
        while (cyc < cr + TO - DB - 3) @(negedge clk);
        x2 = 1'b0;
        while (cyc < cr + TO) begin
            @(posedge clk); #1;
            chk("coincide timeout", timeout, 1'b0);
        end
        chk("coincide f", f, 1'b0);
        @(posedge clk); #1;
        chk("coincide timeout after", timeout, 1'b0);

        // Dropping en restarts the full period.
        step("on2", 1'b0, 1'b0, 1'b1);
        cr = cyc;
        while (cyc < cr + 40) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("en low f", f, 1'b1);
        end
        @(negedge clk) en = 1'b1;
        expiry("restart");

        // Async reset mid-debounce with lamp on; held switch re-toggles after release.
        @(negedge clk) en = 1'b0;
        step("on3", 1'b1, 1'b0, 1'b1);
        @(negedge clk) x2 = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async f", f, 1'b0);
        chk("async x1_db", x1_db, 1'b0);
        chk("async x2_db", x2_db, 1'b0);
        chk("async timeout", timeout, 1'b0);
        @(negedge clk) x2 = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= DB + 3; i++) begin
            @(posedge clk); #1;
            chk("post reset f", f, logic'(i == DB + 3));
        end

        // Random traffic checked against the model every cycle.
        for (int n = 0; n < 2500; n++) begin
            int r;
            int hold;
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 9);
            if (r < 3) x1 = ~x1;
            else if (r < 6) x2 = ~x2;
            else if (r == 6) begin
                x1 = ~x1;
                x2 = ~x2;
            end
            hold = ($urandom_range(0, 19) == 0) ? $urandom_range(60, 90) : $urandom_range(1, DB + 4);
            repeat (hold - 1) @(negedge clk);
        end
        repeat (20) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
